aes_key_expand_seq: RTL

- Sequential AES-128 key expansion unit.
- Accepts the 128-bit cipher key and produces round keys 1..10, one per clock cycle.
- Holds all ten round keys in registers that drive the 10-way round-key selector directly: rk0 = round key 1, …, rk9 = round key 10.
- The round controller starts it once per key change, then indexes the held keys freely.

---
 rtl/aes_key_expand_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key expansion: produces round keys 1..10, one per clock,
// and holds them in a register bank feeding the round-key selector.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] acc;
    logic [7:0] sh;
    logic [7:0] mm;
    acc = 8'h00;
    sh  = x;
    mm  = m;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (mm[0] ? sh : 8'h00);
      sh  = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      mm  = {1'b0, mm[7:1]};
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Forward S-box lookup
  always_comb begin
    y = sbox_f(a);
  end

endmodule

module aes_key_expand_seq #(
  parameter int KEY_WIDTH = 128,
  parameter int NUM_RK    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [KEY_WIDTH-1:0] rk0,
  output logic [KEY_WIDTH-1:0] rk1,
  output logic [KEY_WIDTH-1:0] rk2,
  output logic [KEY_WIDTH-1:0] rk3,
  output logic [KEY_WIDTH-1:0] rk4,
  output logic [KEY_WIDTH-1:0] rk5,
  output logic [KEY_WIDTH-1:0] rk6,
  output logic [KEY_WIDTH-1:0] rk7,
  output logic [KEY_WIDTH-1:0] rk8,
  output logic [KEY_WIDTH-1:0] rk9,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_valid
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  function automatic logic [7:0] xtime_f(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [0:0]           state_r;
  logic [KEY_WIDTH-1:0] cur_key_r;
  logic [7:0]           rcon_r;
  logic [3:0]           cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 keys_valid_r;
  logic [KEY_WIDTH-1:0] rk_r [NUM_RK];

  logic [31:0]          rot_word_s;
  logic [31:0]          sub_word_s;
  logic [31:0]          temp_s;
  logic [31:0]          w0_s, w1_s, w2_s, w3_s;
  logic [KEY_WIDTH-1:0] next_key_s;
  logic                 last_step_s;

  assign rot_word_s = {cur_key_r[23:0], cur_key_r[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_word_s[8*g +: 8]),
      .y (sub_word_s[8*g +: 8])
    );
  end

  // One round of the key schedule from the current key
  always_comb begin
    temp_s      = sub_word_s ^ {rcon_r, 24'h000000};
    w0_s        = cur_key_r[127:96] ^ temp_s;
    w1_s        = cur_key_r[95:64]  ^ w0_s;
    w2_s        = cur_key_r[63:32]  ^ w1_s;
    w3_s        = cur_key_r[31:0]   ^ w2_s;
    next_key_s  = {w0_s, w1_s, w2_s, w3_s};
    last_step_s = (cnt_r == 4'd9);
  end

  // Sequencer: accept start in IDLE, step through ten rounds in EXPAND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cur_key_r    <= {KEY_WIDTH{1'b0}};
      rcon_r       <= 8'h00;
      cnt_r        <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            cur_key_r    <= key_in;
            rcon_r       <= 8'h01;
            cnt_r        <= 4'd0;
            busy_r       <= 1'b1;
            keys_valid_r <= 1'b0;
            state_r      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          cur_key_r <= next_key_s;
          rcon_r    <= xtime_f(rcon_r);
          if (last_step_s) begin
            cnt_r        <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            keys_valid_r <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r  <= cnt_r + 4'd1;
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_RK; g++) begin : g_rk
    // Round-key slot g captures the key produced on its step and then holds
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rk_r[g] <= {KEY_WIDTH{1'b0}};
      end else if ((state_r == ST_EXPAND) && (cnt_r == 4'(g))) begin
        rk_r[g] <= next_key_s;
      end
    end
  end

  assign rk0        = rk_r[0];
  assign rk1        = rk_r[1];
  assign rk2        = rk_r[2];
  assign rk3        = rk_r[3];
  assign rk4        = rk_r[4];
  assign rk5        = rk_r[5];
  assign rk6        = rk_r[6];
  assign rk7        = rk_r[7];
  assign rk8        = rk_r[8];
  assign rk9        = rk_r[9];
  assign busy       = busy_r;
  assign done       = done_r;
  assign keys_valid = keys_valid_r;

endmodule
